// File: rtl/gsm_prod_round_acc.sv
// Frame accumulator for GSM 15x8 products: sums NUM_TERMS products, rounds, shifts and
// saturates to a 16-bit sample. Optional clamping is enabled by defining GSM_ACC_SAT_EN.
module gsm_prod_round_acc #(
    parameter int PROD_WIDTH = 23,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int NUM_TERMS  = 8,
    parameter int SHIFT      = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] in_prod,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat,
    output logic                         busy
);

    localparam int CNT_W = $clog2(NUM_TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TERMS - 1);
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
`ifdef GSM_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                        state, state_nxt;
    logic signed [ACC_WIDTH-1:0]   acc, acc_nxt;
    logic        [CNT_W-1:0]       cnt, cnt_nxt;
    logic signed [OUT_WIDTH-1:0]   data_nxt;
    logic                          valid_nxt;
    logic                          sat_nxt;
    logic signed [ACC_WIDTH:0]     rnd;
    logic signed [ACC_WIDTH:0]     shf;

    // One extra bit keeps the rounding add from overflowing near the accumulator limits.
    assign rnd = (ACC_WIDTH + 1)'(acc) + HALF;
    assign shf = rnd >>> SHIFT;

    // Decoded from registered state only so neither ready depends on a same-cycle input.
    assign in_ready = ap_rst_n && (state == ACCUM);
    assign busy     = ap_rst_n && ((state != ACCUM) || (cnt != '0));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        sat_nxt   = out_sat;
        case (state)
            ACCUM: begin
                if (in_valid && in_ready) begin
                    acc_nxt = acc + ACC_WIDTH'(in_prod);
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ROUND;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ROUND: begin
`ifdef GSM_ACC_SAT_EN
                if (shf > SAT_MAX) begin
                    data_nxt = SAT_MAX[OUT_WIDTH-1:0];
                    sat_nxt  = 1'b1;
                end else if (shf < SAT_MIN) begin
                    data_nxt = SAT_MIN[OUT_WIDTH-1:0];
                    sat_nxt  = 1'b1;
                end else begin
                    data_nxt = OUT_WIDTH'(shf);
                    sat_nxt  = 1'b0;
                end
`else
                data_nxt = OUT_WIDTH'(shf);
                sat_nxt  = 1'b0;
`endif
                valid_nxt = 1'b1;
                acc_nxt   = '0;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    sat_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_gsm_prod_round_acc.sv
// Directed bench for gsm_prod_round_acc: sums, rounding, saturation/wrap, backpressure,
// input gaps and mid-frame reset, with hand-computed expectations.
module tb_gsm_prod_round_acc;

    logic               ap_clk;
    logic               ap_rst_n;
    logic signed [22:0] in_prod;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_sat;
    logic               busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected results for the saturation vectors depend on the build.
`ifdef GSM_ACC_SAT_EN
    localparam int EXP_POS_DATA = 32767;
    localparam int EXP_NEG_DATA = -32768;
    localparam bit EXP_SAT      = 1'b1;
`else
    localparam int EXP_POS_DATA = 0;
    localparam int EXP_NEG_DATA = 0;
    localparam bit EXP_SAT      = 1'b0;
`endif

    gsm_prod_round_acc dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic drive_prod(input int v);
        int k;
        k        = 0;
        in_prod  = v[22:0];
        in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(negedge ap_clk);
            k++;
        end
        if (k >= 50) begin
            total_cnt++;
            $display("FAIL drive_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge ap_clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge ap_clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'sd0) $display("FAIL rst_out_data: got %0d want 0", out_data); else pass_cnt++;
        total_cnt++; if (out_sat !== 1'b0) $display("FAIL rst_out_sat: got %0b want 0", out_sat); else pass_cnt++;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rel_busy: got %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_basic_sum();
        int cyc;
        drive_prod(100);
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy); else pass_cnt++;
        repeat (7) drive_prod(100);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_round_ready: got %0b want 0", in_ready); else pass_cnt++;
        wait_valid(cyc);
        total_cnt++; if (cyc !== 1) $display("FAIL basic_latency: got %0d edges want 1", cyc); else pass_cnt++;
        total_cnt++; if (out_data !== 16'sd3) $display("FAIL basic_data: got %0d want 3", out_data); else pass_cnt++;
        total_cnt++; if (out_sat !== 1'b0) $display("FAIL basic_sat: got %0b want 0", out_sat); else pass_cnt++;
        @(negedge ap_clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %0b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_rounding();
        int first_v[3] = '{48, -48, 255};
        int rest_v[3]  = '{48, -48, 0};
        int exp_v[3]   = '{2, -1, 1};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            drive_prod(first_v[i]);
            repeat (7) drive_prod(rest_v[i]);
            wait_valid(cyc);
            total_cnt++;
            if (!out_valid || out_data !== 16'(exp_v[i]))
                $display("FAIL round_%0d: got %0d valid %0b want %0d", i, out_data, out_valid, exp_v[i]);
            else pass_cnt++;
            @(negedge ap_clk);
        end
    endtask

    task automatic test_saturation();
        int prod_v[2] = '{4194303, -4194304};
        int exp_v[2]  = '{EXP_POS_DATA, EXP_NEG_DATA};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            repeat (8) drive_prod(prod_v[i]);
            wait_valid(cyc);
            total_cnt++;
            if (!out_valid || out_data !== 16'(exp_v[i]))
                $display("FAIL sat_data_%0d: got %0d valid %0b want %0d", i, out_data, out_valid, exp_v[i]);
            else pass_cnt++;
            total_cnt++;
            if (out_sat !== EXP_SAT) $display("FAIL sat_flag_%0d: got %0b want %0b", i, out_sat, EXP_SAT);
            else pass_cnt++;
            @(negedge ap_clk);
            total_cnt++;
            if (out_sat !== 1'b0) $display("FAIL sat_clear_%0d: got %0b want 0", i, out_sat); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        repeat (8) drive_prod(100);
        wait_valid(cyc);
        total_cnt++; if (out_data !== 16'sd3) $display("FAIL bp_data: got %0d want 3", out_data); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_prod  = 23'sd5000;
            @(negedge ap_clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 16'sd3 || in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: got valid %0b data %0d ready %0b want 1/3/0",
                         i, out_valid, out_data, in_ready);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL bp_not_consumed: busy %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_input_gaps();
        int cyc;
        for (int i = 0; i < 8; i++) begin
            drive_prod(256);
            if (i < 7) begin
                @(negedge ap_clk);
                total_cnt++;
                if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
                    $display("FAIL gap_%0d: got busy %0b ready %0b valid %0b want 1/1/0",
                             i, busy, in_ready, out_valid);
                else pass_cnt++;
            end
        end
        wait_valid(cyc);
        total_cnt++; if (cyc !== 1) $display("FAIL gap_latency: got %0d edges want 1", cyc); else pass_cnt++;
        total_cnt++; if (out_data !== 16'sd8) $display("FAIL gap_data: got %0d want 8", out_data); else pass_cnt++;
        @(negedge ap_clk);
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        repeat (3) drive_prod(1000);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'sd0 || out_sat !== 1'b0)
            $display("FAIL midrst_outputs: got ready %0b busy %0b valid %0b data %0d sat %0b want all 0",
                     in_ready, busy, out_valid, out_data, out_sat);
        else pass_cnt++;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_release: got busy %0b ready %0b want 0/1", busy, in_ready);
        else pass_cnt++;
        repeat (8) drive_prod(256);
        wait_valid(cyc);
        total_cnt++; if (out_data !== 16'sd8) $display("FAIL midrst_data: got %0d want 8", out_data); else pass_cnt++;
        @(negedge ap_clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        repeat (8) drive_prod(100);
        wait_valid(cyc);
        total_cnt++; if (out_data !== 16'sd3) $display("FAIL b2b_first: got %0d want 3", out_data); else pass_cnt++;
        @(negedge ap_clk);
        repeat (8) drive_prod(-100);
        wait_valid(cyc);
        total_cnt++; if (cyc !== 1) $display("FAIL b2b_latency: got %0d edges want 1", cyc); else pass_cnt++;
        total_cnt++; if (out_data !== -16'sd3) $display("FAIL b2b_second: got %0d want -3", out_data); else pass_cnt++;
        @(negedge ap_clk);
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
